// File: rtl/run_detect_ctrl.sv
// Run-length pattern detector controller: holds run length, arms/disarms,
// counts hits per polarity and reports them on a valid/ready event port.
module run_detect_ctrl #(
    parameter int LEN_W   = 4,
    parameter int CNT_W   = 16,
    parameter int DEF_LEN = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cfg_wr,
    input  logic [LEN_W-1:0] cfg_len,
    output logic             cfg_err,
    input  logic             start,
    input  logic             stop,
    input  logic             bit_vld,
    input  logic             bit_in,
    output logic             match,
    output logic             busy,
    output logic             evt_valid,
    input  logic             evt_ready,
    output logic             evt_pol,
    output logic             evt_ovf,
    output logic [CNT_W-1:0] cnt_ones,
    output logic [CNT_W-1:0] cnt_zeros
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    localparam logic [LEN_W-1:0] LEN_MAX = '1;
    localparam logic [LEN_W-1:0] LEN_DEF = LEN_W'(DEF_LEN);
    localparam logic [LEN_W-1:0] LEN_MIN = LEN_W'(2);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t           state_q, state_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [LEN_W-1:0] run_q, run_d;
    logic             last_q, last_d;
    logic [CNT_W-1:0] ones_q, ones_d;
    logic [CNT_W-1:0] zeros_q, zeros_d;
    logic             evv_q, evv_d;
    logic             evp_q, evp_d;
    logic             ovf_q, ovf_d;
    logic             err_q, err_d;

    logic             arm;
    logic             run_en;
    logic             cont;
    logic [LEN_W-1:0] nrun;
    logic             hit;
    logic             cfg_ok;

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (start)      state_d = S_RUN;
            S_RUN:   if (stop)       state_d = S_DRAIN;
            S_DRAIN: if (!evv_q)     state_d = S_IDLE;
            default:                 state_d = S_IDLE;
        endcase
    end

    // FSM-derived controls
    always_comb begin
        arm    = (state_q == S_IDLE) && start;
        run_en = (state_q == S_RUN);
        busy   = (state_q != S_IDLE);
    end

    // Run tracking; the counter saturates so very long runs keep hitting
    always_comb begin
        cont = (run_q != '0) && (bit_in == last_q);
        if (!cont) begin
            nrun = LEN_W'(1);
        end else if (run_q == LEN_MAX) begin
            nrun = LEN_MAX;
        end else begin
            nrun = run_q + LEN_W'(1);
        end
        hit = run_en && bit_vld && (nrun >= len_q);
    end

    always_comb begin
        run_d  = run_q;
        last_d = last_q;
        if (arm) begin
            run_d = '0;
        end else if (run_en && bit_vld) begin
            run_d  = nrun;
            last_d = bit_in;
        end
    end

    // Saturating per-polarity hit counters
    always_comb begin
        ones_d  = ones_q;
        zeros_d = zeros_q;
        if (arm) begin
            ones_d  = '0;
            zeros_d = '0;
        end else if (hit) begin
            if (bit_in) begin
                if (ones_q != CNT_MAX) ones_d = ones_q + CNT_W'(1);
            end else begin
                if (zeros_q != CNT_MAX) zeros_d = zeros_q + CNT_W'(1);
            end
        end
    end

    // Event port: a hit replaces only a free or accepted slot
    always_comb begin
        evv_d = evv_q;
        evp_d = evp_q;
        ovf_d = ovf_q;
        if (arm) begin
            ovf_d = 1'b0;
        end
        if (hit && (!evv_q || evt_ready)) begin
            evv_d = 1'b1;
            evp_d = bit_in;
        end else if (hit) begin
            ovf_d = 1'b1;
        end else if (evv_q && evt_ready) begin
            evv_d = 1'b0;
        end
    end

    // Configuration
    always_comb begin
        cfg_ok = cfg_wr && (state_q == S_IDLE) && (cfg_len >= LEN_MIN);
        len_d  = cfg_ok ? cfg_len : len_q;
        err_d  = cfg_wr && !cfg_ok;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            len_q   <= LEN_DEF;
            run_q   <= '0;
            last_q  <= 1'b0;
            ones_q  <= '0;
            zeros_q <= '0;
            evv_q   <= 1'b0;
            evp_q   <= 1'b0;
            ovf_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            len_q   <= len_d;
            run_q   <= run_d;
            last_q  <= last_d;
            ones_q  <= ones_d;
            zeros_q <= zeros_d;
            evv_q   <= evv_d;
            evp_q   <= evp_d;
            ovf_q   <= ovf_d;
            err_q   <= err_d;
        end
    end

    // Output logic
    always_comb begin
        match     = hit;
        cfg_err   = err_q;
        evt_valid = evv_q;
        evt_pol   = evp_q;
        evt_ovf   = ovf_q;
        cnt_ones  = ones_q;
        cnt_zeros = zeros_q;
    end

endmodule

// File: tb/tb_run_detect_ctrl.sv
// Directed bench for run_detect_ctrl: vector table plus corner sequences.
module tb_run_detect_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        cfg_wr;
    logic [3:0]  cfg_len;
    logic        start, stop, bit_vld, bit_in, evt_ready;
    logic        cfg_err, match, busy, evt_valid, evt_pol, evt_ovf;
    logic [15:0] cnt_ones, cnt_zeros;
    logic        s_cfg_err, s_match, s_busy, s_evv, s_evp, s_ovf;
    logic [1:0]  s_ones, s_zeros;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    run_detect_ctrl dut (
        .clk(clk), .reset(reset), .cfg_wr(cfg_wr), .cfg_len(cfg_len),
        .cfg_err(cfg_err), .start(start), .stop(stop), .bit_vld(bit_vld),
        .bit_in(bit_in), .match(match), .busy(busy), .evt_valid(evt_valid),
        .evt_ready(evt_ready), .evt_pol(evt_pol), .evt_ovf(evt_ovf),
        .cnt_ones(cnt_ones), .cnt_zeros(cnt_zeros)
    );

    run_detect_ctrl #(.CNT_W(2)) dut_s (
        .clk(clk), .reset(reset), .cfg_wr(cfg_wr), .cfg_len(cfg_len),
        .cfg_err(s_cfg_err), .start(start), .stop(stop), .bit_vld(bit_vld),
        .bit_in(bit_in), .match(s_match), .busy(s_busy), .evt_valid(s_evv),
        .evt_ready(evt_ready), .evt_pol(s_evp), .evt_ovf(s_ovf),
        .cnt_ones(s_ones), .cnt_zeros(s_zeros)
    );

    typedef struct {
        logic st, sp, vld, b, rdy;
        logic m, bsy, ev, pol;
        logic [15:0] ones, zeros;
    } vec_t;

    vec_t tv[$];

    function automatic vec_t mk(logic st, logic sp, logic vld, logic b,
                                logic rdy, logic m, logic bsy, logic ev,
                                logic pol, int ones, int zeros);
        vec_t r;
        r.st = st; r.sp = sp; r.vld = vld; r.b = b; r.rdy = rdy;
        r.m = m; r.bsy = bsy; r.ev = ev; r.pol = pol;
        r.ones = 16'(ones); r.zeros = 16'(zeros);
        return r;
    endfunction

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        cfg_wr = 0; cfg_len = 0; start = 0; stop = 0;
        bit_vld = 0; bit_in = 0;
    endtask

    task automatic bits_run(input int n, input logic b, output int hits,
                            output int first);
        hits = 0;
        first = -1;
        for (int i = 0; i < n; i++) begin
            bit_vld = 1; bit_in = b;
            #1;
            if (match) begin
                hits++;
                if (first < 0) first = i;
            end
            cyc();
        end
        bit_vld = 0;
    endtask

    task automatic wait_idle(input string name);
        int k;
        k = 0;
        while (busy && k < 5) begin
            cyc();
            k++;
        end
        chk(name, 64'(busy), 64'(0));
    endtask

    initial begin
        int hits, first;
        logic [35:0] act, exp;

        reset = 0; evt_ready = 1;
        idle_in();
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs",
            {match, cfg_err, busy, evt_valid, evt_pol, evt_ovf,
             cnt_ones, cnt_zeros}, 64'(0));
        reset = 1;
        cyc();

        // T1 overlapping hits then T2 gap inside a run
        tv.push_back(mk(1,0,0,0,1, 0,0,0,0, 0,0));
        tv.push_back(mk(0,0,1,1,1, 0,1,0,0, 0,0));
        tv.push_back(mk(0,0,1,1,1, 0,1,0,0, 0,0));
        tv.push_back(mk(0,0,1,1,1, 1,1,0,0, 0,0));
        tv.push_back(mk(0,0,1,1,1, 1,1,1,1, 1,0));
        tv.push_back(mk(0,0,1,0,1, 0,1,1,1, 2,0));
        tv.push_back(mk(0,0,1,0,1, 0,1,0,0, 2,0));
        tv.push_back(mk(0,0,1,0,1, 1,1,0,0, 2,0));
        tv.push_back(mk(0,0,0,0,1, 0,1,1,0, 2,1));
        tv.push_back(mk(0,0,0,0,1, 0,1,0,0, 2,1));
        tv.push_back(mk(0,1,0,0,1, 0,1,0,0, 2,1));
        tv.push_back(mk(0,0,0,0,1, 0,1,0,0, 2,1));
        tv.push_back(mk(1,0,0,0,1, 0,0,0,0, 2,1));
        tv.push_back(mk(0,0,1,1,1, 0,1,0,0, 0,0));
        tv.push_back(mk(0,0,1,1,1, 0,1,0,0, 0,0));
        tv.push_back(mk(0,0,0,1,1, 0,1,0,0, 0,0));
        tv.push_back(mk(0,0,0,1,1, 0,1,0,0, 0,0));
        tv.push_back(mk(0,0,0,1,1, 0,1,0,0, 0,0));
        tv.push_back(mk(0,0,1,1,1, 1,1,0,0, 0,0));
        tv.push_back(mk(0,0,0,0,1, 0,1,1,1, 1,0));
        tv.push_back(mk(0,1,0,0,1, 0,1,0,0, 1,0));
        tv.push_back(mk(0,0,0,0,1, 0,1,0,0, 1,0));
        tv.push_back(mk(0,0,0,0,1, 0,0,0,0, 1,0));

        foreach (tv[i]) begin
            start = tv[i].st; stop = tv[i].sp; bit_vld = tv[i].vld;
            bit_in = tv[i].b; evt_ready = tv[i].rdy;
            #1;
            act = {match, busy, evt_valid, evt_pol & evt_valid,
                   cnt_ones, cnt_zeros};
            exp = {tv[i].m, tv[i].bsy, tv[i].ev, tv[i].pol,
                   tv[i].ones, tv[i].zeros};
            chk($sformatf("vec%0d", i), 64'(act), 64'(exp));
            cyc();
        end
        idle_in();

        // T3 backpressure and overflow
        evt_ready = 0;
        start = 1; cyc(); start = 0;
        bits_run(3, 1'b1, hits, first);
        chk("t3_first_evt", {evt_valid, evt_pol}, 64'(2'b11));
        bits_run(3, 1'b0, hits, first);
        chk("t3_ovf_state",
            {evt_valid, evt_pol, evt_ovf, cnt_ones, cnt_zeros},
            {3'b111, 16'd1, 16'd1});
        evt_ready = 1;
        cyc();
        chk("t3_accept", 64'(evt_valid), 64'(0));
        stop = 1; cyc(); stop = 0;
        wait_idle("t3_idle");

        // T4 configuration
        cfg_wr = 1; cfg_len = 5; cyc(); cfg_wr = 0;
        chk("t4_cfg_ok", 64'(cfg_err), 64'(0));
        start = 1; cyc(); start = 0;
        chk("t4_ovf_clr", 64'(evt_ovf), 64'(0));
        bits_run(5, 1'b1, hits, first);
        chk("t4_len5", {32'(hits), 32'(first)}, {32'd1, 32'd4});
        cfg_wr = 1; cfg_len = 2; cyc(); cfg_wr = 0;
        chk("t4_err_run", 64'(cfg_err), 64'(1));
        cyc();
        chk("t4_err_pulse", 64'(cfg_err), 64'(0));
        stop = 1; cyc(); stop = 0;
        wait_idle("t4_idle");
        cfg_wr = 1; cfg_len = 1; cyc(); cfg_wr = 0;
        chk("t4_err_len1", 64'(cfg_err), 64'(1));
        start = 1; cyc(); start = 0;
        bits_run(5, 1'b0, hits, first);
        chk("t4_len_kept", {32'(hits), 32'(first)}, {32'd1, 32'd4});
        stop = 1; cyc(); stop = 0;
        wait_idle("t4_idle2");

        // T5 drain with a pending event
        cfg_wr = 1; cfg_len = 3; cyc(); cfg_wr = 0;
        evt_ready = 0;
        start = 1; cyc(); start = 0;
        bits_run(3, 1'b1, hits, first);
        stop = 1; cyc(); stop = 0;
        chk("t5_drain", {busy, evt_valid}, 64'(2'b11));
        bits_run(4, 1'b0, hits, first);
        chk("t5_ignored", {32'(hits), cnt_zeros, cnt_ones},
            {32'd0, 16'd0, 16'd1});
        chk("t5_still_busy", 64'(busy), 64'(1));
        evt_ready = 1;
        cyc();
        chk("t5_accept", 64'(evt_valid), 64'(0));
        wait_idle("t5_idle");

        // T6 saturation and async reset
        cfg_wr = 1; cfg_len = 4; cyc(); cfg_wr = 0;
        start = 1; cyc(); start = 0;
        bits_run(20, 1'b1, hits, first);
        chk("t6_run_sat", {32'(hits), 16'(cnt_ones)}, {32'd17, 16'd17});
        chk("t6_cnt_sat", 64'(s_ones), 64'(3));
        bit_vld = 1; bit_in = 1;
        #1;
        chk("t6_pre_reset", 64'(match), 64'(1));
        #1 reset = 0;
        #1;
        chk("t6_async_reset",
            {match, cfg_err, busy, evt_valid, evt_pol, evt_ovf,
             cnt_ones, cnt_zeros, s_ones, s_busy}, 64'(0));
        cyc();
        reset = 1;
        idle_in();
        start = 1; cyc(); start = 0;
        bits_run(3, 1'b1, hits, first);
        chk("t6_len_default", {32'(hits), 32'(first)}, {32'd1, 32'd2});

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
